// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed number of
// wait states; misaligned or out-of-range accesses complete with err=1.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [33:0]   LIMIT    = 34'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  // With zero wait states IDLE goes straight to RESP, so the transaction is
  // judged on the values being captured on that same edge.
  logic              t_we;
  logic [31:0]       t_addr;
  logic [31:0]       t_wdata;
  logic [3:0]        t_be;
  logic              t_err;
  logic [IDX_W-1:0]  t_idx;
  logic              enter_resp;
  logic              mem_we;

  always_comb begin
    t_we    = (state_q == IDLE) ? we    : we_q;
    t_addr  = (state_q == IDLE) ? addr  : addr_q;
    t_wdata = (state_q == IDLE) ? wdata : wdata_q;
    t_be    = (state_q == IDLE) ? be    : be_q;
    t_err   = (t_addr[1:0] != 2'b00) || ({2'b00, t_addr} >= LIMIT);
    t_idx   = t_addr[IDX_W+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 32'h0;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) enter_resp = 1'b1;
        else             cnt_d = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d = RESP;
      ready_d = 1'b1;
      err_d   = t_err;
      rdata_d = (t_we || t_err) ? 32'h0 : mem_q[t_idx];
      mem_we  = t_we && !t_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory contents survive reset; only the write strobe is blocked during it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (t_be[b]) mem_q[t_idx][8*b +: 8] <= t_wdata[8*b +: 8];
      end
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a 2-wait-state instance for the data path
// and a 0-wait-state instance for back-to-back request spacing.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .rdata(rdata), .err(err)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency is counted in cycles from the one in which the request is presented
  // (the capture cycle counts as 1); -1 means ready never arrived.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input logic chg, input logic [31:0] ca,
                     input logic [31:0] cwd, output logic [31:0] rd,
                     output logic e, output int lat);
    logic seen;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    seen = 1'b0; lat = -1; rd = 32'hx; e = 1'bx;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1 && chg) begin
        addr = ca; wdata = cwd;
      end
      if (ready) begin
        seen = 1'b1; lat = i; rd = rdata; e = err; req = 1'b0;
      end
    end
    req = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'b0, ready}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          pulses;
  int          first_idx, second_idx;

  initial begin
    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_err",   {31'b0, err},   32'h0);
    check("rst_rdata", rdata,          32'h0);
    reset = 1'b0;

    // full-word store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("st10_lat", lat, 3);
    check("st10_err", {31'b0, e}, 32'h0);
    check("st10_rdata", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 0, rd, e, lat);
    check("ld10_lat", lat, 3);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", {31'b0, e}, 32'h0);

    // single-byte store merges into existing word
    txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 0, 0, rd, e, lat);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("ld10_be1", rd, 32'hDEADBEAA);

    // be=0000 store completes without changing memory
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 0, 0, rd, e, lat);
    check("st_be0_lat", lat, 3);
    check("st_be0_err", {31'b0, e}, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 0, rd, e, lat);
    check("ld10_after_be0", rd, 32'hDEADBEAA);

    // error cases; word 0 aliases 0x400 in the low address bits
    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 0, 0, rd, e, lat);
    txn(1'b0, 32'h12, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("ld12_err", {31'b0, e}, 32'h1);
    check("ld12_rdata", rd, 32'h0);
    txn(1'b0, 32'h400, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("ld400_err", {31'b0, e}, 32'h1);
    check("ld400_rdata", rd, 32'h0);
    txn(1'b1, 32'h400, 32'h55555555, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("st400_err", {31'b0, e}, 32'h1);
    check("st400_lat", lat, 3);
    txn(1'b1, 32'h13, 32'h66666666, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("st13_err", {31'b0, e}, 32'h1);
    txn(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("ld0_unchanged", rd, 32'h0BADF00D);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("ld10_unchanged", rd, 32'hDEADBEAA);

    // reset during WAIT abandons the store
    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 0, 0, rd, e, lat);
    pulses = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    if (ready) pulses++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ready", {31'b0, ready}, 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b0;
      if (ready) pulses++;
    end
    check("rst_no_pulse", pulses, 0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("post_rst_lat", lat, 3);
    check("ld20_prior", rd, 32'hCAFEF00D);

    // inputs changed during WAIT do not affect the transaction
    txn(1'b1, 32'h30, 32'h11112222, 4'hF, 1'b1, 32'h10, 32'h99999999, rd, e, lat);
    check("chg_st_err", {31'b0, e}, 32'h0);
    txn(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 0, 0, rd, e, lat);
    check("chg_ld30", rd, 32'h11112222);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'h13, 32'h0, rd, e, lat);
    check("chg_ld10", rd, 32'hDEADBEAA);
    check("chg_ld10_err", {31'b0, e}, 32'h0);

    // zero wait states, req held high across two requests
    first_idx = -1; second_idx = -1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h2; be0 = 4'hF;
    for (int i = 1; i <= 10 && second_idx < 0; i++) begin
      @(negedge clk);
      if (ready0) begin
        if (first_idx < 0) begin
          first_idx = i;
          check("w0_err", {31'b0, err0}, 32'h1);
          check("w0_rdata", rdata0, 32'h0);
        end else begin
          second_idx = i;
          req0 = 1'b0;
        end
      end
    end
    req0 = 1'b0;
    check("w0_first_lat", first_idx, 1);
    check("w0_spacing", second_idx - first_idx, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 SHALL provide DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 SHALL provide WAIT_CYCLES, default 2: wait states inserted between request capture and response (0 allowed).

Interface
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  initiator request, held high until ready is seen.
REQ-006 SHALL have port we  input  1  1 = store, 0 = fetch/load.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port be  input  4  byte enables; bit i controls wdata[8i+7:8i].
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  read data, valid only while ready=1.
REQ-012 SHALL have port err  output  1  error flag, valid only while ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: on a clk edge with req=1, SHALL capture we, addr, wdata and be.
REQ-015 From IDLE, SHALL go to WAIT when WAIT_CYCLES>0, else directly to RESP.
REQ-016 WAIT: SHALL load a wait counter with WAIT_CYCLES-1 on entry and decrement it each cycle.
REQ-017 WAIT: SHALL go to RESP on the edge where the counter is 0.
REQ-018 RESP: SHALL assert ready for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: ready SHALL rise WAIT_CYCLES+1 cycles after the capture edge.
REQ-020 All outputs SHALL be registered.
REQ-021 Address checks SHALL use captured values only; inputs that change after capture SHALL have no effect on the transaction in progress.
REQ-022 Misaligned access (addr[1:0]!=0) SHALL be an error.
REQ-023 Out-of-range access (addr >= 4*DEPTH_WORDS) SHALL be an error.
REQ-024 On error, SHALL assert err=1 and rdata=0 in RESP and SHALL leave memory unmodified.
REQ-025 Store without error: memory[addr>>2] SHALL be updated, enabled bytes only, on the edge entering RESP.
REQ-026 Store: SHALL drive rdata=0 in RESP.
REQ-027 Store with be=0000 SHALL complete normally with no memory change.
REQ-028 Load without error: rdata SHALL hold the full word memory[addr>>2] in RESP; be is ignored.
REQ-029 Load: SHALL drive err=0 in RESP.
REQ-030 Outside RESP, SHALL hold ready=0, err=0, rdata=0.
REQ-031 req deasserted during WAIT SHALL NOT abort the transaction; it SHALL complete normally (abort not supported).
REQ-032 req still high in IDLE after a response SHALL start a new transaction; minimum request-to-request spacing SHALL be WAIT_CYCLES+2 cycles.
REQ-033 A store followed by a load to the same word SHALL return the stored data (no hazard).

Reset
REQ-034 reset SHALL force state IDLE, ready=0, err=0, rdata=0 and wait counter 0 immediately.
REQ-035 reset SHALL NOT clear memory contents.
REQ-036 reset mid-WAIT SHALL abandon the transaction with no response and no memory write.
REQ-037 The first request after reset deassertion SHALL be captured normally.

Verification
REQ-038 Bench SHALL apply store addr=0x10, wdata=0xDEADBEEF, be=1111, WAIT_CYCLES=2, then load 0x10 -> each ready exactly 3 cycles after capture; load returns rdata=0xDEADBEEF, err=0.
REQ-039 Bench SHALL apply store addr=0x10, wdata=0x000000AA, be=0001 over 0xDEADBEEF -> load 0x10 returns 0xDEADBEAA.
REQ-040 Bench SHALL apply load addr=0x12, then load addr=0x400 with DEPTH_WORDS=256 -> both give err=1, rdata=0; a store to 0x400 changes no word.
REQ-041 Bench SHALL assert reset during WAIT of store 0x20 = 0x12345678 -> ready never pulses; a later load of 0x20 returns the prior contents.
REQ-042 Bench SHALL hold req high continuously for two loads with WAIT_CYCLES=0 -> ready pulses spaced exactly 2 cycles apart.
REQ-043 Bench SHALL change addr and wdata during WAIT -> response reflects the captured values.
